// File: rtl/synth_pkg.sv
// Shared definitions for the synth front end: FSM encoding, event polarity
// and the default note/velocity widths used by the shaper bank.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RETRIG = 2'd3
    } state_t;

    localparam logic EVT_NOTE_ON  = 1'b1;
    localparam logic EVT_NOTE_OFF = 1'b0;

    // Widths must match the shaper bank inputs
    localparam int DEF_NOTE_BITS = 7;
    localparam int DEF_VEL_BITS  = 32;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters and the oldest-enabled-voice search.
// Only instantiated when voice stealing (VOICE_ALLOC_STEAL_EN) is built in.
module voice_age_tracker #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_BITS   = 8,
    localparam int IW        = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_VOICES-1:0] en_i,
    input  logic                  upd_i,
    input  logic [IW-1:0]         tgt_i,
    output logic                  oldest_ok_o,
    output logic [IW-1:0]         oldest_idx_o
);

    logic [NUM_VOICES-1:0][AGE_BITS-1:0] age_q;

    // On every allocation: target restarts at 0, other sounding voices age by one
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else if (upd_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IW'(i) == tgt_i)
                    age_q[i] <= '0;
                else if (en_i[i] && (age_q[i] != {AGE_BITS{1'b1}}))
                    age_q[i] <= age_q[i] + 1'b1;
            end
        end
    end

    // Oldest enabled voice; strict '>' keeps the lowest index on ties
    always_comb begin
        logic [AGE_BITS-1:0] best;
        oldest_ok_o  = 1'b0;
        oldest_idx_o = '0;
        best         = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (en_i[i] && (!oldest_ok_o || (age_q[i] > best))) begin
                oldest_ok_o  = 1'b1;
                oldest_idx_o = IW'(i);
                best         = age_q[i];
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: accepts note-on/off events, scans the voices one per
// cycle, then assigns/retriggers/releases a voice in a single COMMIT cycle.
// Build option VOICE_ALLOC_STEAL_EN: when no voice is free, steal the oldest
// sounding voice instead of dropping the note-on.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_BITS  = DEF_NOTE_BITS,
    parameter int VEL_BITS   = DEF_VEL_BITS,
    parameter int AGE_BITS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           evt_valid,
    output logic                           evt_ready,
    input  logic                           evt_on,
    input  logic [NOTE_BITS-1:0]           evt_note,
    input  logic [VEL_BITS-1:0]            evt_velocity,
    input  logic [NUM_VOICES-1:0]          voice_available,
    output logic [NUM_VOICES-1:0]          voice_en,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
    output logic [NUM_VOICES*VEL_BITS-1:0]  voice_velocity,
    output logic [15:0]                    drop_count
);

    localparam int IW = $clog2(NUM_VOICES);

    state_t                               state_q, state_d;
    logic [IW-1:0]                        idx_q, idx_d;
    logic                                 ev_on_q, ev_on_d;
    logic [NOTE_BITS-1:0]                 ev_note_q, ev_note_d;
    logic [VEL_BITS-1:0]                  ev_vel_q, ev_vel_d;
    logic                                 held_ok_q, held_ok_d;
    logic [IW-1:0]                        held_idx_q, held_idx_d;
    logic                                 free_ok_q, free_ok_d;
    logic [IW-1:0]                        free_idx_q, free_idx_d;
    logic [IW-1:0]                        tgt_q, tgt_d;
    logic [NUM_VOICES-1:0]                en_q, en_d;
    logic [NUM_VOICES-1:0][NOTE_BITS-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0][VEL_BITS-1:0]  vel_q, vel_d;
    logic [15:0]                          drop_q, drop_d;

    // COMMIT decision
    logic          cm_retrig, cm_alloc, cm_off, cm_drop;
    logic [IW-1:0] cm_tgt;
    logic          steal_ok;
    logic [IW-1:0] steal_idx;

`ifdef VOICE_ALLOC_STEAL_EN
    logic age_upd;
    assign age_upd = cm_retrig | cm_alloc;

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_BITS   (AGE_BITS)
    ) u_age (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_q),
        .upd_i        (age_upd),
        .tgt_i        (cm_tgt),
        .oldest_ok_o  (steal_ok),
        .oldest_idx_o (steal_idx)
    );
`else
    assign steal_ok  = 1'b0;
    assign steal_idx = '0;
`endif

    assign evt_ready      = (state_q == ST_IDLE);
    assign voice_en       = en_q;
    assign voice_note     = note_q;
    assign voice_velocity = vel_q;
    assign drop_count     = drop_q;

    // Pick the COMMIT action from the scan results (held > free > steal > drop)
    always_comb begin
        cm_retrig = 1'b0;
        cm_alloc  = 1'b0;
        cm_off    = 1'b0;
        cm_drop   = 1'b0;
        cm_tgt    = '0;
        if (state_q == ST_COMMIT) begin
            if (ev_on_q == EVT_NOTE_ON) begin
                if (held_ok_q) begin
                    cm_retrig = 1'b1;
                    cm_tgt    = held_idx_q;
                end else if (free_ok_q) begin
                    cm_alloc  = 1'b1;
                    cm_tgt    = free_idx_q;
                end else if (steal_ok) begin
                    cm_retrig = 1'b1;
                    cm_tgt    = steal_idx;
                end else begin
                    cm_drop   = 1'b1;
                end
            end else begin
                if (held_ok_q) begin
                    cm_off = 1'b1;
                    cm_tgt = held_idx_q;
                end else begin
                    cm_drop = 1'b1;
                end
            end
        end
    end

    // FSM next state and datapath updates
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ev_on_d    = ev_on_q;
        ev_note_d  = ev_note_q;
        ev_vel_d   = ev_vel_q;
        held_ok_d  = held_ok_q;
        held_idx_d = held_idx_q;
        free_ok_d  = free_ok_q;
        free_idx_d = free_idx_q;
        tgt_d      = tgt_q;
        en_d       = en_q;
        note_d     = note_q;
        vel_d      = vel_q;
        drop_d     = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (evt_valid) begin
                    ev_on_d   = evt_on;
                    ev_note_d = evt_note;
                    ev_vel_d  = evt_velocity;
                    idx_d     = '0;
                    held_ok_d = 1'b0;
                    free_ok_d = 1'b0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // voice_available is looked at only here, once per voice
                if (!held_ok_q && en_q[idx_q] && (note_q[idx_q] == ev_note_q)) begin
                    held_ok_d  = 1'b1;
                    held_idx_d = idx_q;
                end
                if (!free_ok_q && !en_q[idx_q] && voice_available[idx_q]) begin
                    free_ok_d  = 1'b1;
                    free_idx_d = idx_q;
                end
                if (idx_q == IW'(NUM_VOICES - 1))
                    state_d = ST_COMMIT;
                else
                    idx_d = idx_q + 1'b1;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (cm_retrig) begin
                    // One en-low cycle restarts the shaper envelope
                    en_d[cm_tgt]   = 1'b0;
                    note_d[cm_tgt] = ev_note_q;
                    vel_d[cm_tgt]  = ev_vel_q;
                    tgt_d          = cm_tgt;
                    state_d        = ST_RETRIG;
                end
                if (cm_alloc) begin
                    en_d[cm_tgt]   = 1'b1;
                    note_d[cm_tgt] = ev_note_q;
                    vel_d[cm_tgt]  = ev_vel_q;
                end
                // Note and velocity kept so the release keeps its pitch
                if (cm_off)
                    en_d[cm_tgt] = 1'b0;
                if (cm_drop && (drop_q != 16'hFFFF))
                    drop_d = drop_q + 16'd1;
            end
            ST_RETRIG: begin
                en_d[tgt_q] = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            ev_on_q    <= 1'b0;
            ev_note_q  <= '0;
            ev_vel_q   <= '0;
            held_ok_q  <= 1'b0;
            held_idx_q <= '0;
            free_ok_q  <= 1'b0;
            free_idx_q <= '0;
            tgt_q      <= '0;
            en_q       <= '0;
            note_q     <= '0;
            vel_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ev_on_q    <= ev_on_d;
            ev_note_q  <= ev_note_d;
            ev_vel_q   <= ev_vel_d;
            held_ok_q  <= held_ok_d;
            held_idx_q <= held_idx_d;
            free_ok_q  <= free_ok_d;
            free_idx_q <= free_idx_d;
            tgt_q      <= tgt_d;
            en_q       <= en_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with 4 voices.
// Expectations for the full-bank note-on follow VOICE_ALLOC_STEAL_EN.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NB = 7;
    localparam int VB = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           evt_valid = 1'b0;
    logic           evt_ready;
    logic           evt_on = 1'b0;
    logic [NB-1:0]  evt_note = '0;
    logic [VB-1:0]  evt_velocity = '0;
    logic [NV-1:0]  voice_available = '1;
    logic [NV-1:0]  voice_en;
    logic [NV*NB-1:0] voice_note;
    logic [NV*VB-1:0] voice_velocity;
    logic [15:0]    drop_count;

    int checks = 0;
    int errors = 0;
    logic [NV-1:0] hist [0:63];

    always #5 clk = ~clk;

    voice_allocator #(
        .NUM_VOICES (NV),
        .NOTE_BITS  (NB),
        .VEL_BITS   (VB),
        .AGE_BITS   (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_on          (evt_on),
        .evt_note        (evt_note),
        .evt_velocity    (evt_velocity),
        .voice_available (voice_available),
        .voice_en        (voice_en),
        .voice_note      (voice_note),
        .voice_velocity  (voice_velocity),
        .drop_count      (drop_count)
    );

    function automatic logic [NB-1:0] vn(input int i);
        return voice_note[i*NB +: NB];
    endfunction

    function automatic logic [VB-1:0] vv(input int i);
        return voice_velocity[i*VB +: VB];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        evt_valid = 1'b0;
        voice_available = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one event; return the cycle (after the handshake) where ready returns
    task automatic do_evt(input logic on, input logic [NB-1:0] n, input logic [VB-1:0] v,
                          output int lat);
        int w;
        w = 0;
        while (!evt_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        evt_valid = 1'b1;
        evt_on = on;
        evt_note = n;
        evt_velocity = v;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            hist[lat] = voice_en;
        end while (!evt_ready && lat < 60);
        if (lat >= 60) begin
            checks++; errors++;
            $display("FAIL evt_timeout ready never returned after %0d cycles", lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (evt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", evt_ready); end
        checks++;
        if (voice_en !== 4'b0000) begin errors++; $display("FAIL reset_en got %b exp 0000", voice_en); end
        checks++;
        if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        checks++;
        if (voice_note !== '0 || voice_velocity !== '0) begin
            errors++; $display("FAIL reset_note_vel got %h/%h exp 0", voice_note, voice_velocity);
        end
        rst = 1'b0;
    endtask

    task automatic test_alloc();
        int lat;
        do_reset();
        do_evt(1'b1, 7'd60, 32'd100, lat);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL alloc_latency got %0d exp 6", lat); end
        checks++;
        if (hist[5] !== 4'b0000) begin errors++; $display("FAIL alloc_early en got %b exp 0000", hist[5]); end
        checks++;
        if (voice_en !== 4'b0001) begin errors++; $display("FAIL alloc_en got %b exp 0001", voice_en); end
        checks++;
        if (vn(0) !== 7'd60 || vv(0) !== 32'd100) begin
            errors++; $display("FAIL alloc_note_vel got %0d/%0d exp 60/100", vn(0), vv(0));
        end
    endtask

    task automatic test_release();
        int lat;
        do_reset();
        do_evt(1'b1, 7'd60, 32'd1, lat);
        do_evt(1'b1, 7'd62, 32'd2, lat);
        do_evt(1'b1, 7'd64, 32'd3, lat);
        do_evt(1'b0, 7'd62, 32'd99, lat);
        checks++;
        if (voice_en !== 4'b0101) begin errors++; $display("FAIL release_en got %b exp 0101", voice_en); end
        checks++;
        if (vn(1) !== 7'd62 || vv(1) !== 32'd2) begin
            errors++; $display("FAIL release_keep got %0d/%0d exp 62/2", vn(1), vv(1));
        end
        voice_available = 4'b1101;
        do_evt(1'b1, 7'd65, 32'd4, lat);
        checks++;
        if (voice_en !== 4'b1101 || vn(3) !== 7'd65) begin
            errors++; $display("FAIL busy_skip got en %b note3 %0d exp 1101/65", voice_en, vn(3));
        end
        voice_available = '1;
    endtask

    task automatic test_retrig();
        int lat;
        do_reset();
        do_evt(1'b1, 7'd60, 32'd10, lat);
        do_evt(1'b1, 7'd60, 32'd20, lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL retrig_latency got %0d exp 7", lat); end
        checks++;
        if (hist[5] !== 4'b0001 || hist[6] !== 4'b0000 || hist[7] !== 4'b0001) begin
            errors++; $display("FAIL retrig_pulse got %b %b %b exp 0001 0000 0001", hist[5], hist[6], hist[7]);
        end
        checks++;
        if (vv(0) !== 32'd20 || vn(0) !== 7'd60) begin
            errors++; $display("FAIL retrig_vel got %0d/%0d exp 60/20", vn(0), vv(0));
        end
    endtask

    task automatic test_full();
        int lat;
        do_reset();
        for (int i = 0; i < 4; i++) do_evt(1'b1, 7'(60 + i), 32'(i + 1), lat);
        do_evt(1'b1, 7'd70, 32'd77, lat);
`ifdef VOICE_ALLOC_STEAL_EN
        checks++;
        if (lat !== 7 || hist[6] !== 4'b1110) begin
            errors++; $display("FAIL steal_pulse got lat %0d en %b exp 7/1110", lat, hist[6]);
        end
        checks++;
        if (voice_en !== 4'b1111 || vn(0) !== 7'd70 || vv(0) !== 32'd77 || drop_count !== 16'd0) begin
            errors++; $display("FAIL steal_result got en %b note0 %0d vel0 %0d drop %0d exp 1111/70/77/0",
                               voice_en, vn(0), vv(0), drop_count);
        end
`else
        checks++;
        if (drop_count !== 16'd1) begin errors++; $display("FAIL full_drop got %0d exp 1", drop_count); end
        checks++;
        if (voice_en !== 4'b1111 || vn(0) !== 7'd60 || lat !== 6) begin
            errors++; $display("FAIL full_nochange got en %b note0 %0d lat %0d exp 1111/60/6", voice_en, vn(0), lat);
        end
`endif
    endtask

    task automatic test_drop_and_reset();
        int lat;
        do_reset();
        do_evt(1'b1, 7'd60, 32'd5, lat);
        do_evt(1'b0, 7'd50, 32'd0, lat);
        checks++;
        if (drop_count !== 16'd1 || voice_en !== 4'b0001) begin
            errors++; $display("FAIL off_drop got drop %0d en %b exp 1/0001", drop_count, voice_en);
        end
        // Reset while the next event is mid-scan
        evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd61; evt_velocity = 32'd6;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (evt_ready !== 1'b0) begin errors++; $display("FAIL scan_busy got ready %b exp 0", evt_ready); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (voice_en !== 4'b0000 || evt_ready !== 1'b1 || drop_count !== 16'd0) begin
            errors++; $display("FAIL scan_reset got en %b rdy %b drop %0d exp 0000/1/0", voice_en, evt_ready, drop_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] acc [$];
        int w;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            evt_valid = 1'b1; evt_on = 1'b1;
            evt_note = 7'(40 + k); evt_velocity = 32'(k);
            if (evt_ready) acc.push_back(evt_note);
            @(negedge clk);
        end
        evt_valid = 1'b0;
        w = 0;
        while (!evt_ready && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (acc.size() !== 4) begin
            errors++; $display("FAIL b2b_count got %0d exp 4", acc.size());
        end else begin
            checks++;
            if (acc[0] !== 7'd40 || acc[1] !== 7'd46 || acc[2] !== 7'd52 || acc[3] !== 7'd58) begin
                errors++; $display("FAIL b2b_accepted got %0d %0d %0d %0d exp 40 46 52 58", acc[0], acc[1], acc[2], acc[3]);
            end
        end
        checks++;
        if (voice_en !== 4'b1111 || vn(0) !== 7'd40 || vn(1) !== 7'd46 || vn(2) !== 7'd52 || vn(3) !== 7'd58) begin
            errors++; $display("FAIL b2b_voices got en %b notes %0d %0d %0d %0d exp 1111 40 46 52 58",
                               voice_en, vn(0), vn(1), vn(2), vn(3));
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_release();
        test_retrig();
        test_full();
        test_drop_and_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
